// File: rtl/mkio_rt_engine.sv
// rtl/mkio_rt_engine.sv - MIL-STD-1553 style remote-terminal message engine with dual-port subaddress buffer.
// Optional feature: define MKIO_BROADCAST_EN to accept receive commands addressed to 31.
module mkio_rt_engine #(
  parameter logic [4:0] ADDRESS    = 5'd1,
  parameter int         SA_NUM     = 4,
  parameter int         PAUSE_CYC  = 255,
  parameter int         STROBE_CYC = 3,
  parameter int         RX_TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  input  logic                        rx_valid,
  input  logic [15:0]                 rx_data,
  input  logic                        p_error,
  output logic [15:0]                 tx_data,
  output logic                        tx_cd,
  output logic                        tx_ready,
  input  logic                        tx_busy,
  input  logic [$clog2(SA_NUM)+4:0]   host_addr,
  input  logic [15:0]                 host_wdata,
  input  logic                        host_we,
  output logic [15:0]                 host_rdata,
  output logic                        busy,
  output logic                        msg_done,
  output logic                        msg_err
);

  localparam int AW = $clog2(SA_NUM) + 5;

  typedef enum logic [3:0] {
    IDLE, DECODE, RX_WAIT, RX_STORE, PAUSE, LOAD_SW, SEND_SW,
    RD_MEM, SEND_WAIT, SEND_DW, CHECK, END_WAIT
  } state_t;

  state_t      state_q;
  logic        tr_q;
  logic [4:0]  sa_q;
  logic [5:0]  total_q;
  logic [5:0]  words_q;
  logic [4:0]  idx_q;
  logic [15:0] tmr_q;
  logic        err_q;
  logic [15:0] rx_word_q;
  logic [15:0] eng_rdata_q;
  logic [15:0] host_rdata_q;
  logic [15:0] tx_data_q;
  logic        tx_cd_q;
  logic        tx_ready_q;
  logic        busy_q;
  logic        msg_done_q;
  logic        msg_err_q;
`ifdef MKIO_BROADCAST_EN
  logic        bcast_q;
  logic [15:0] bcast_status_q;
`endif

  logic [15:0] mem [0:(1<<AW)-1];

  logic [4:0]  cmd_addr_d;
  logic        cmd_t_d;
  logic [4:0]  cmd_sa_d;
  logic [4:0]  cmd_cnt_d;
  logic        addr_ok_d;
  logic        accept_d;
  logic [AW-1:0] eng_addr_d;

  assign cmd_addr_d = rx_data[15:11];
  assign cmd_t_d    = rx_data[10];
  assign cmd_sa_d   = rx_data[9:5];
  assign cmd_cnt_d  = rx_data[4:0];

`ifdef MKIO_BROADCAST_EN
  assign addr_ok_d = (cmd_addr_d == ADDRESS) || ((cmd_addr_d == 5'd31) && !cmd_t_d);
`else
  assign addr_ok_d = (cmd_addr_d == ADDRESS);
`endif

  assign accept_d   = cmd_valid && addr_ok_d && (int'(cmd_sa_d) < SA_NUM);
  // Word index is only 5 bits, so it wraps inside the subaddress page.
  assign eng_addr_d = AW'({sa_q, idx_q});

  // Host write wins a same-address collision; both ports read every cycle.
  always_ff @(posedge clk) begin
    if (state_q == RX_STORE) mem[eng_addr_d] <= rx_word_q;
    if (host_we) mem[host_addr] <= host_wdata;
    host_rdata_q <= mem[host_addr];
    eng_rdata_q  <= mem[eng_addr_d];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      tr_q       <= 1'b0;
      sa_q       <= 5'd0;
      total_q    <= 6'd0;
      words_q    <= 6'd0;
      idx_q      <= 5'd0;
      tmr_q      <= 16'd0;
      err_q      <= 1'b0;
      rx_word_q  <= 16'd0;
      tx_data_q  <= 16'd0;
      tx_cd_q    <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      msg_done_q <= 1'b0;
      msg_err_q  <= 1'b0;
`ifdef MKIO_BROADCAST_EN
      bcast_q        <= 1'b0;
      bcast_status_q <= 16'd0;
`endif
    end else begin
      msg_done_q <= 1'b0;
      if (accept_d) begin
        state_q    <= DECODE;
        tr_q       <= cmd_t_d;
        sa_q       <= cmd_sa_d;
        total_q    <= {(cmd_cnt_d == 5'd0), cmd_cnt_d};
        words_q    <= 6'd0;
        idx_q      <= 5'd0;
        tmr_q      <= 16'd0;
        err_q      <= p_error;
        tx_ready_q <= 1'b0;
        busy_q     <= 1'b1;
        msg_err_q  <= 1'b0;
`ifdef MKIO_BROADCAST_EN
        bcast_q    <= (cmd_addr_d == 5'd31);
`endif
      end else begin
        case (state_q)
          IDLE: ;
          DECODE: begin
            tmr_q   <= 16'd0;
            state_q <= tr_q ? PAUSE : RX_WAIT;
          end
          RX_WAIT: begin
            if (rx_valid) begin
              rx_word_q <= rx_data;
              err_q     <= err_q | p_error;
              tmr_q     <= 16'd0;
              state_q   <= RX_STORE;
            end else if (tmr_q == 16'(RX_TIMEOUT)) begin
              err_q      <= 1'b1;
              busy_q     <= 1'b0;
              msg_done_q <= 1'b1;
              msg_err_q  <= 1'b1;
              state_q    <= IDLE;
            end else begin
              tmr_q <= tmr_q + 16'd1;
            end
          end
          RX_STORE: begin
            idx_q   <= idx_q + 5'd1;
            words_q <= words_q + 6'd1;
            tmr_q   <= 16'd0;
            state_q <= (words_q + 6'd1 == total_q) ? PAUSE : RX_WAIT;
          end
          PAUSE: begin
            if (tmr_q == 16'(PAUSE_CYC - 1)) begin
              tmr_q   <= 16'd0;
              state_q <= LOAD_SW;
            end else begin
              tmr_q <= tmr_q + 16'd1;
            end
          end
          LOAD_SW: begin
`ifdef MKIO_BROADCAST_EN
            if (bcast_q) begin
              bcast_status_q <= {ADDRESS, err_q, 10'd0};
              state_q        <= END_WAIT;
            end else begin
              tx_data_q  <= {ADDRESS, err_q, 10'd0};
              tx_cd_q    <= 1'b0;
              tx_ready_q <= 1'b1;
              tmr_q      <= 16'd0;
              state_q    <= SEND_SW;
            end
`else
            tx_data_q  <= {ADDRESS, err_q, 10'd0};
            tx_cd_q    <= 1'b0;
            tx_ready_q <= 1'b1;
            tmr_q      <= 16'd0;
            state_q    <= SEND_SW;
`endif
          end
          SEND_SW: begin
            if (tmr_q == 16'(STROBE_CYC - 1)) begin
              tx_ready_q <= 1'b0;
              tmr_q      <= 16'd0;
              state_q    <= tr_q ? RD_MEM : END_WAIT;
            end else begin
              tmr_q <= tmr_q + 16'd1;
            end
          end
          RD_MEM: state_q <= SEND_WAIT;
          SEND_WAIT: begin
            if (!tx_busy) begin
              tx_data_q  <= eng_rdata_q;
              tx_cd_q    <= 1'b1;
              tx_ready_q <= 1'b1;
              tmr_q      <= 16'd0;
              state_q    <= SEND_DW;
            end
          end
          SEND_DW: begin
            if (tmr_q == 16'(STROBE_CYC - 1)) begin
              tx_ready_q <= 1'b0;
              tmr_q      <= 16'd0;
              idx_q      <= idx_q + 5'd1;
              words_q    <= words_q + 6'd1;
              state_q    <= CHECK;
            end else begin
              tmr_q <= tmr_q + 16'd1;
            end
          end
          CHECK: state_q <= (words_q == total_q) ? END_WAIT : RD_MEM;
          END_WAIT: begin
            if (!tx_busy) begin
              busy_q     <= 1'b0;
              msg_done_q <= 1'b1;
              msg_err_q  <= err_q;
              state_q    <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_cd      = tx_cd_q;
  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign msg_done   = msg_done_q;
  assign msg_err    = msg_err_q;
  assign host_rdata = host_rdata_q;

endmodule
